apc_stim_arbiter: RTL
=====================

Name: apc_stim_arbiter

Overview:
- Two-requester, frame-granular round-robin arbiter that shares the single APC stimulus input stream (complex re/im samples plus valid) between two sample sources.
- Sits between the stimulus generators and the APC datapath.
- Locks the grant for a whole frame.
- Enforces a programmable idle guard gap between frames.
- Terminates frames that exceed a maximum length.

Parameters:
- DATA_BITS, 32, width of each of the re and im sample words.
- GAP_CYCLES, 4, minimum idle cycles on the output between frames; 0 allowed.
- MAX_FRAME_LEN, 1024, maximum samples per output frame; must be ≥1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- s0_data_re  input  DATA_BITS  source 0 real sample.
- s0_data_im  input  DATA_BITS  source 0 imaginary sample.
- s0_valid  input  1  source 0 sample valid.
- s0_last  input  1  source 0 final sample of frame.
- s0_ready  output  1  source 0 sample accepted when high with s0_valid.
- s1_data_re, s1_data_im, s1_valid, s1_last, s1_ready: same as source 0, for source 1.
- m_data_re  output  DATA_BITS  real sample to APC.
- m_data_im  output  DATA_BITS  imaginary sample to APC.
- m_valid  output  1  output sample valid; no backpressure from APC.
- m_last  output  1  final sample of output frame.
- grant  output  2  one-hot current owner; 00 when none.
- err_overlong  output  1  one-cycle pulse when a frame is force-terminated.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0: m_data_re/m_data_im, m_valid, m_last, grant, err_overlong, s0_ready, s1_ready.
  - last_served = 1, so source 0 wins the first contention.
  - Sample counter and gap counter = 0.
- FSM states: IDLE, GRANT0, GRANT1, GAP.
- IDLE:
  - No ready asserted.
  - One source valid: go to its GRANTx next cycle.
  - Both valid: grant the source != last_served.
  - Neither valid: stay.
  - The decision cycle transfers nothing.
- GRANTx:
  - sx_ready = 1, decoded from the registered state only, never from valid.
  - grant = one-hot x; the other ready stays 0.
  - A transfer happens when sx_valid & sx_ready.
  - On transfer: register data to m_data_*, set m_valid=1, m_last=sx_last, and increment the sample counter.
  - Latency is exactly 1 cycle, source handshake to m_valid.
  - Cycles with sx_valid=0 inside a frame give m_valid=0; the grant is held and bubbles pass through.
  - m_data_* hold their last value when m_valid=0.
- Frame end:
  - Triggered by a transfer with sx_last=1, or by the transfer that makes the sample count equal MAX_FRAME_LEN.
  - On frame end: last_served = x, counter cleared, ready drops the following cycle.
  - Next state is GAP if GAP_CYCLES > 0, else IDLE.
- Overlong termination:
  - Applies when the count reaches MAX_FRAME_LEN without sx_last.
  - The output sample carries m_last=1 and err_overlong pulses in the same cycle as that m_valid.
  - Remaining source samples arbitrate later as a new frame.
  - If sx_last coincides with count==MAX_FRAME_LEN, it is a normal end with no error.
- GAP:
  - Readies low and grant = 00.
  - Counts GAP_CYCLES cycles, then goes to IDLE.
  - Output idle gap between frames is therefore ≥ GAP_CYCLES+1 cycles, counting the IDLE decision cycle.
- Sample counter width is clog2(MAX_FRAME_LEN+1); it never wraps.
- Source valid behaviour:
  - Source valid dropping mid-frame has no effect on ownership.
  - Valid asserted by the non-granted source is ignored until a later IDLE.
- Reset asserted mid-frame:
  - Outputs clear immediately and asynchronously.
  - The partial frame is abandoned; m_last is not emitted.
- After reset deasserts, operation resumes from IDLE with source 0 priority.

Test Plan:
1. Single source: s0 sends 3 samples (re=1,2,3; im=−1,−2,−3), last on 3 → m_valid for 3 cycles, each 1 cycle after its handshake, m_last on sample 3 only. grant=01 throughout. s1_ready=0.
2. Contention: s0 and s1 both hold valid with 2-sample frames, GAP_CYCLES=4:
   - Output order is s0 frame, then s1 frame, then s0 frame.
   - Idle between frames is ≥5 cycles.
   - grant sequence 01, 00, 10, 00, 01.
3. Bubbles: s1 frame of 4 samples with s1_valid low on cycle 2 → m_valid pattern 1,0,1,1,1. grant stays 10. s0_valid asserted meanwhile is not accepted until the frame ends.
4. Overlong: MAX_FRAME_LEN=8, s0 streams 10 samples with last on sample 10:
   - Sample 8 is output with m_last=1 and err_overlong=1 for one cycle.
   - Samples 9–10 form a second frame after the gap, with m_last on sample 10 and no error.
5. Boundary: MAX_FRAME_LEN=8, last on exactly sample 8 → m_last=1, err_overlong stays 0.
6. Reset mid-frame: assert rst during sample 2 of a 5-sample s1 frame:
   - All outputs 0 immediately, no m_last.
   - After release, s0 and s1 contend and s0 is granted first.

Source files
------------

// File: rtl/apc_stim_arbiter.sv
// Two-source, frame-granular round-robin arbiter for the APC stimulus stream.
// Grant is held for a whole frame, followed by an idle guard gap; overlong frames are cut.
module apc_stim_arbiter #(
  parameter int DATA_BITS     = 32,
  parameter int GAP_CYCLES    = 4,
  parameter int MAX_FRAME_LEN = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] s0_data_re,
  input  logic [DATA_BITS-1:0] s0_data_im,
  input  logic                 s0_valid,
  input  logic                 s0_last,
  output logic                 s0_ready,
  input  logic [DATA_BITS-1:0] s1_data_re,
  input  logic [DATA_BITS-1:0] s1_data_im,
  input  logic                 s1_valid,
  input  logic                 s1_last,
  output logic                 s1_ready,
  output logic [DATA_BITS-1:0] m_data_re,
  output logic [DATA_BITS-1:0] m_data_im,
  output logic                 m_valid,
  output logic                 m_last,
  output logic [1:0]           grant,
  output logic                 err_overlong
);

  localparam int CNT_W    = $clog2(MAX_FRAME_LEN + 1);
  localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 lastServed_q, lastServed_d;
  logic [CNT_W-1:0]     sampleCnt_q, sampleCnt_d;
  logic [GAP_W-1:0]     gapCnt_q, gapCnt_d;
  logic [DATA_BITS-1:0] dataRe_q, dataRe_d;
  logic [DATA_BITS-1:0] dataIm_q, dataIm_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;

  logic                 selS1;
  logic                 selValid;
  logic                 selLast;
  logic [DATA_BITS-1:0] selRe;
  logic [DATA_BITS-1:0] selIm;
  logic [CNT_W-1:0]     cntInc;
  logic                 cntHit;

  // Source mux follows the registered owner only, so ready never depends on valid.
  assign selS1    = (state_q == GRANT1);
  assign selValid = selS1 ? s1_valid   : s0_valid;
  assign selLast  = selS1 ? s1_last    : s0_last;
  assign selRe    = selS1 ? s1_data_re : s0_data_re;
  assign selIm    = selS1 ? s1_data_im : s0_data_im;
  assign cntInc   = sampleCnt_q + CNT_W'(1);
  assign cntHit   = (cntInc == CNT_W'(MAX_FRAME_LEN));

  always_comb begin
    state_d      = state_q;
    lastServed_d = lastServed_q;
    sampleCnt_d  = sampleCnt_q;
    gapCnt_d     = gapCnt_q;
    dataRe_d     = dataRe_q;
    dataIm_d     = dataIm_q;
    valid_d      = 1'b0;
    last_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_valid && s1_valid) begin
          state_d = lastServed_q ? GRANT0 : GRANT1;
        end else if (s0_valid) begin
          state_d = GRANT0;
        end else if (s1_valid) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (selValid) begin
          dataRe_d = selRe;
          dataIm_d = selIm;
          valid_d  = 1'b1;
          last_d   = selLast | cntHit;
          err_d    = cntHit & ~selLast;
          if (selLast || cntHit) begin
            sampleCnt_d  = '0;
            lastServed_d = selS1;
            state_d      = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            sampleCnt_d = cntInc;
          end
        end
      end
      GAP: begin
        if (gapCnt_q == GAP_W'(GAP_LAST)) begin
          gapCnt_d = '0;
          state_d  = IDLE;
        end else begin
          gapCnt_d = gapCnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lastServed_q <= 1'b1;
      sampleCnt_q  <= '0;
      gapCnt_q     <= '0;
      dataRe_q     <= '0;
      dataIm_q     <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lastServed_q <= lastServed_d;
      sampleCnt_q  <= sampleCnt_d;
      gapCnt_q     <= gapCnt_d;
      dataRe_q     <= dataRe_d;
      dataIm_q     <= dataIm_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      err_q        <= err_d;
    end
  end

  assign grant        = {state_q == GRANT1, state_q == GRANT0};
  assign s0_ready     = grant[0];
  assign s1_ready     = grant[1];
  assign m_data_re    = dataRe_q;
  assign m_data_im    = dataIm_q;
  assign m_valid      = valid_q;
  assign m_last       = last_q;
  assign err_overlong = err_q;

endmodule
